// File: rtl/data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter
//
// Two-port arbiter in front of a single-ported synchronous memory. Port 0 is
// the CPU data port, port 1 the loader/debug port. In IDLE, one requester is
// granted combinationally and its access is driven onto the memory bus in the
// same cycle. Writes complete in the grant cycle. Reads take one extra cycle
// (RD_WAIT), in which the memory read data is returned to the granted port.
// A rotating priority pointer (prio) breaks ties. A port that holds reqLock
// keeps priority after its grant.
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous, active-low reset
//   reqValid[1:0]  per-port request
//   reqWrite[1:0]  per-port request type (1 = write, 0 = read)
//   reqLock[1:0]   per-port lock (keep priority after grant)
//   reqAddr0/1     per-port address
//   reqData0/1     per-port write data
//   reqGnt[1:0]    per-port grant; the request is accepted while high
//   rspValid[1:0]  per-port read-data-valid pulse
//   rspData        shared read data, qualified by rspValid
//   memEn          memory access strobe
//   memWrEnable    memory write strobe
//   memAddr        memory address
//   memWrData      memory write data
//   memRdData      memory read data, valid one cycle after a read strobe
//   conflictCount  saturating count of IDLE cycles with both ports requesting
// -----------------------------------------------------------------------------
module data_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        reqValid,
    input  logic [1:0]        reqWrite,
    input  logic [1:0]        reqLock,
    input  logic [ADDR_W-1:0] reqAddr0,
    input  logic [ADDR_W-1:0] reqAddr1,
    input  logic [DATA_W-1:0] reqData0,
    input  logic [DATA_W-1:0] reqData1,
    output logic [1:0]        reqGnt,
    output logic [1:0]        rspValid,
    output logic [DATA_W-1:0] rspData,
    output logic              memEn,
    output logic              memWrEnable,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWrData,
    input  logic [DATA_W-1:0] memRdData,
    output logic [CNT_W-1:0]  conflictCount
);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t state;
    logic   prio;         // port that wins when both request
    logic   rdPort;       // port that owns the outstanding read
    logic   winner;
    logic   grantActive;

    // Winner selection, grant and memory-bus drive. The grant is gated by rst
    // so that nothing is granted while reset is held, even in IDLE.
    always_comb begin
        // NOTE: every signal written here gets a default before any condition,
        // so no path leaves it unassigned and no latch is inferred.
        winner      = prio;
        grantActive = rst && (state == IDLE) && (reqValid != 2'b00);
        reqGnt      = 2'b00;
        memEn       = 1'b0;
        memWrEnable = 1'b0;
        rspValid    = 2'b00;
        rspData     = '0;

        if (reqValid == 2'b01) begin
            winner = 1'b0;
        end else if (reqValid == 2'b10) begin
            winner = 1'b1;
        end

        // Address and data follow the winner unconditionally; they only
        // matter while memEn is high.
        memAddr   = winner ? reqAddr1 : reqAddr0;
        memWrData = winner ? reqData1 : reqData0;

        if (grantActive) begin
            reqGnt[winner] = 1'b1;
            memEn          = 1'b1;
            memWrEnable    = reqWrite[winner];
        end

        if (state == RD_WAIT) begin
            rspValid[rdPort] = 1'b1;
            rspData          = memRdData;
        end
    end

    // State, priority pointer and conflict counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            prio          <= 1'b0;
            rdPort        <= 1'b0;
            conflictCount <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            case (state)
                IDLE: begin
                    if (grantActive) begin
                        // A locked grant keeps priority; otherwise it rotates.
                        prio <= reqLock[winner] ? winner : ~winner;
                        if (!reqWrite[winner]) begin
                            state  <= RD_WAIT;
                            rdPort <= winner;
                        end
                    end
                    if ((reqValid == 2'b11) && (conflictCount != {CNT_W{1'b1}})) begin
                        conflictCount <= conflictCount + 1'b1;
                    end
                end
                RD_WAIT: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_bus_arbiter
//
// Directed bench for data_bus_arbiter. The stimulus process drives requests
// and pushes the hand-computed grant/response it expects into a scoreboard
// queue. A monitor pops and compares whenever the DUT shows a grant or a read
// response. Reset state, idle behaviour and conflict counts are checked
// directly by the stimulus. A second instance with CNT_W = 2 shares all
// inputs and is used for counter saturation.
// -----------------------------------------------------------------------------
module tb_data_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic          isRsp;
        logic [1:0]    gnt;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    rspV;
        logic [DW-1:0] rdata;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [1:0]    reqValid;
    logic [1:0]    reqWrite;
    logic [1:0]    reqLock;
    logic [AW-1:0] reqAddr0;
    logic [AW-1:0] reqAddr1;
    logic [DW-1:0] reqData0;
    logic [DW-1:0] reqData1;
    logic [1:0]    reqGnt;
    logic [1:0]    rspValid;
    logic [DW-1:0] rspData;
    logic          memEn;
    logic          memWrEnable;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWrData;
    logic [DW-1:0] memRdData;
    logic [15:0]   conflictCount;

    logic [1:0]    reqGnt2;
    logic [1:0]    rspValid2;
    logic [DW-1:0] rspData2;
    logic          memEn2;
    logic          memWrEnable2;
    logic [AW-1:0] memAddr2;
    logic [DW-1:0] memWrData2;
    logic [1:0]    conflictCount2;

    exp_t          sb[$];
    int            nChecks = 0;
    int            nPass   = 0;
    logic [DW-1:0] mem [256];

    data_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqWrite(reqWrite), .reqLock(reqLock),
        .reqAddr0(reqAddr0), .reqAddr1(reqAddr1),
        .reqData0(reqData0), .reqData1(reqData1),
        .reqGnt(reqGnt), .rspValid(rspValid), .rspData(rspData),
        .memEn(memEn), .memWrEnable(memWrEnable),
        .memAddr(memAddr), .memWrData(memWrData),
        .memRdData(memRdData), .conflictCount(conflictCount)
    );

    data_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(2)) dutSat (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqWrite(reqWrite), .reqLock(reqLock),
        .reqAddr0(reqAddr0), .reqAddr1(reqAddr1),
        .reqData0(reqData0), .reqData1(reqData1),
        .reqGnt(reqGnt2), .rspValid(rspValid2), .rspData(rspData2),
        .memEn(memEn2), .memWrEnable(memWrEnable2),
        .memAddr(memAddr2), .memWrData(memWrData2),
        .memRdData(memRdData), .conflictCount(conflictCount2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple synchronous memory behind the main instance: read data one
    // cycle after the read strobe, writes land on the strobe edge.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h40] = 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        if (memEn && !memWrEnable) memRdData <= mem[memAddr[7:0]];
        if (memEn && memWrEnable)  mem[memAddr[7:0]] <= memWrData;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            nPass++;
        end
    endtask

    task automatic pushGnt(input logic [1:0] gnt, input logic wr,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        exp_t e;
        e.isRsp = 1'b0; e.gnt = gnt; e.wr = wr; e.addr = addr; e.wdata = wdata;
        e.rspV = 2'b00; e.rdata = '0;
        sb.push_back(e);
    endtask

    task automatic pushRsp(input logic [1:0] rspV, input logic [DW-1:0] rdata);
        exp_t e;
        e.isRsp = 1'b1; e.gnt = 2'b00; e.wr = 1'b0; e.addr = '0; e.wdata = '0;
        e.rspV = rspV; e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input logic [1:0] v, input logic [1:0] w, input logic [1:0] l);
        reqValid = v;
        reqWrite = w;
        reqLock  = l;
    endtask

    // One cycle with no requests; the bus must stay quiet.
    task automatic idleCycle(input string tag);
        setReq(2'b00, 2'b00, 2'b00);
        @(negedge clk);
        check({tag, "_gnt"},   64'(reqGnt),      64'd0);
        check({tag, "_rspv"},  64'(rspValid),    64'd0);
        check({tag, "_memen"}, 64'(memEn),       64'd0);
        check({tag, "_memwr"}, 64'(memWrEnable), 64'd0);
        cycle();
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_gnt"},   64'(reqGnt),        64'd0);
        check({tag, "_rspv"},  64'(rspValid),      64'd0);
        check({tag, "_memen"}, 64'(memEn),         64'd0);
        check({tag, "_memwr"}, 64'(memWrEnable),   64'd0);
        check({tag, "_rdata"}, 64'(rspData),       64'd0);
        check({tag, "_cnt"},   64'(conflictCount), 64'd0);
    endtask

    // Scoreboard monitor: any grant or response must match the next entry.
    always @(negedge clk) begin
        if (rst && (reqGnt != 2'b00 || rspValid != 2'b00)) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {60'd0, reqGnt, rspValid}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (!e.isRsp) begin
                    check("mon_gnt",      64'(reqGnt),      64'(e.gnt));
                    check("mon_memen",    64'(memEn),       64'd1);
                    check("mon_memwr",    64'(memWrEnable), 64'(e.wr));
                    check("mon_memaddr",  64'(memAddr),     64'(e.addr));
                    if (e.wr) check("mon_memwdata", 64'(memWrData), 64'(e.wdata));
                    check("mon_no_rspv",  64'(rspValid),    64'd0);
                end else begin
                    check("mon_rspv",     64'(rspValid),    64'(e.rspV));
                    check("mon_rdata",    64'(rspData),     64'(e.rdata));
                    check("mon_rsp_gnt0", 64'(reqGnt),      64'd0);
                    check("mon_rsp_men0", 64'(memEn),       64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] rot4 [4];
        logic [1:0] rot6 [6];
        logic [1:0] sat6 [6];
        rot4 = '{2'b01, 2'b10, 2'b01, 2'b10};
        rot6 = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        sat6 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        rst = 1'b0;
        setReq(2'b00, 2'b00, 2'b00);
        reqAddr0 = '0; reqAddr1 = '0; reqData0 = '0; reqData1 = '0;
        repeat (2) cycle();

        // Reset held with both ports requesting: nothing may be granted.
        setReq(2'b11, 2'b00, 2'b00);
        @(negedge clk);
        checkResetOutputs("reset");
        cycle();
        rst = 1'b1;
        setReq(2'b00, 2'b00, 2'b00);

        // Port 1 read of 0x40: grant in T, response in T+1 with grant low
        // even though port 1 keeps requesting.
        setReq(2'b10, 2'b00, 2'b00);
        reqAddr1 = 32'h40;
        pushGnt(2'b10, 1'b0, 32'h40, '0);
        pushRsp(2'b10, 32'hDEAD_BEEF);
        cycle();
        cycle();
        idleCycle("after_read");
        check("cnt_after_read", 64'(conflictCount), 64'd0);

        // Both ports writing, no lock: strict alternation, 4 conflicts.
        for (int i = 0; i < 4; i++) begin
            setReq(2'b11, 2'b11, 2'b00);
            reqAddr0 = 32'h100 + i; reqData0 = 32'hA000_0000 + i;
            reqAddr1 = 32'h200 + i; reqData1 = 32'hB000_0000 + i;
            if (rot4[i] == 2'b01) pushGnt(2'b01, 1'b1, reqAddr0, reqData0);
            else                  pushGnt(2'b10, 1'b1, reqAddr1, reqData1);
            cycle();
        end
        check("cnt_rotate", 64'(conflictCount), 64'd4);
        idleCycle("after_rotate");

        // Port 0 locked for three contended writes, then it stops; port 1
        // is granted on the next cycle.
        for (int i = 0; i < 3; i++) begin
            setReq(2'b11, 2'b11, 2'b01);
            reqAddr0 = 32'h300 + i; reqData0 = 32'hC000_0000 + i;
            reqAddr1 = 32'h400;     reqData1 = 32'hD000_0000;
            pushGnt(2'b01, 1'b1, reqAddr0, reqData0);
            cycle();
        end
        setReq(2'b10, 2'b11, 2'b00);
        pushGnt(2'b10, 1'b1, 32'h400, 32'hD000_0000);
        cycle();
        check("cnt_lock", 64'(conflictCount), 64'd7);
        idleCycle("after_lock");

        // Port 0 read, then reset during RD_WAIT. Before reset prio points
        // to port 1, so a contended grant of port 0 shows prio was cleared.
        setReq(2'b01, 2'b00, 2'b00);
        reqAddr0 = 32'h44;
        pushGnt(2'b01, 1'b0, 32'h44, '0);
        cycle();
        rst = 1'b0;
        setReq(2'b00, 2'b00, 2'b00);
        @(negedge clk);
        checkResetOutputs("abort");
        cycle();
        rst = 1'b1;
        idleCycle("post_abort");
        setReq(2'b11, 2'b11, 2'b00);
        reqAddr0 = 32'h500; reqData0 = 32'hE000_0000;
        reqAddr1 = 32'h600; reqData1 = 32'hF000_0000;
        pushGnt(2'b01, 1'b1, 32'h500, 32'hE000_0000);
        cycle();
        check("cnt_post_abort", 64'(conflictCount), 64'd1);
        idleCycle("after_abort");

        // Fresh reset, six contended cycles: 2-bit counter saturates at 3.
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            setReq(2'b11, 2'b11, 2'b00);
            reqAddr0 = 32'h700 + i; reqData0 = 32'h1111_0000 + i;
            reqAddr1 = 32'h800 + i; reqData1 = 32'h2222_0000 + i;
            if (rot6[i] == 2'b01) pushGnt(2'b01, 1'b1, reqAddr0, reqData0);
            else                  pushGnt(2'b10, 1'b1, reqAddr1, reqData1);
            cycle();
            check($sformatf("cnt_sat_%0d", i), 64'(conflictCount2), 64'(sat6[i]));
        end
        check("cnt_wide_6", 64'(conflictCount), 64'd6);
        idleCycle("after_sat");

        // Port 0 write to 0x10, then port 1 reads it back the next cycle.
        setReq(2'b01, 2'b01, 2'b00);
        reqAddr0 = 32'h10; reqData0 = 32'hCAFE_0010;
        pushGnt(2'b01, 1'b1, 32'h10, 32'hCAFE_0010);
        cycle();
        setReq(2'b10, 2'b00, 2'b00);
        reqAddr1 = 32'h10;
        pushGnt(2'b10, 1'b0, 32'h10, '0);
        pushRsp(2'b10, 32'hCAFE_0010);
        cycle();
        setReq(2'b00, 2'b00, 2'b00);
        cycle();
        idleCycle("final");

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
